// File: rtl/lcd_bus_sequencer.sv
// lcd_bus_sequencer
//   Owns the 8-bit parallel write bus of a 12864 (ST7920) LCD. Shares the bus
//   round-robin between NUM_REQ byte writers and produces timed rs/dat/en
//   strobes followed by the controller execution wait.
//
//   Build option: define LCD_INIT_SEQ_EN to compile in the power-on wait and
//   the init command sequence (0x30, 0x0C, 0x01, 0x06) that runs before any
//   requester is served. Without it the bus is usable straight out of reset.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   PWRUP  | power-on wait before the init sequence (init build only)
//   IDLE   | bus free; arbitrate among valid requesters
//   SETUP  | rs/dat driven, en low
//   STROBE | en high
//   HOLD   | en low again, rs/dat held
//   GAP    | controller execution wait (long after clear/home)

module lcd_bus_sequencer #(
  parameter int NUM_REQ       = 2,
  parameter int SETUP_CYC     = 2,
  parameter int EN_HIGH_CYC   = 3,
  parameter int HOLD_CYC      = 2,
  parameter int CMD_GAP_CYC   = 5,
  parameter int CLEAR_GAP_CYC = 20,
  parameter int POWERUP_CYC   = 10,
  parameter int CNT_W         = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_rs,
  input  logic [8*NUM_REQ-1:0] req_dat,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic                 lcd_rs,
  output logic                 lcd_rw,
  output logic                 lcd_en,
  output logic [7:0]           lcd_dat,
  output logic                 busy,
  output logic                 init_done
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_PWRUP,
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_GAP
  } state_t;

`ifdef LCD_INIT_SEQ_EN
  localparam state_t S_RESET = S_PWRUP;
`else
  localparam state_t S_RESET = S_IDLE;
`endif

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_load;
  logic [CNT_W-1:0]     w_gap_load;
  logic                 w_reload;

  logic [PTR_W-1:0]     r_ptr;
  logic [PTR_W-1:0]     w_ptr_nxt;
  logic [2*NUM_REQ-1:0] w_valid_dbl;
  logic [NUM_REQ-1:0]   w_valid_rot;
  logic                 w_grant_found;
  logic [NUM_REQ-1:0]   w_grant_oh;
  int                   w_off;
  int                   w_sum;
  int                   w_nxt_sum;
  logic                 w_sel_rs;
  logic [7:0]           w_sel_dat;

  logic                 w_load_req;
  logic [NUM_REQ-1:0]   w_ack_nxt;
  logic [NUM_REQ-1:0]   r_ack;
  logic                 r_lcd_rs;
  logic                 r_lcd_en;
  logic [7:0]           r_lcd_dat;
  logic                 w_init_done;

`ifdef LCD_INIT_SEQ_EN
  logic                 r_init_done;
  logic [1:0]           r_init_idx;
  logic [1:0]           w_init_sel;
  logic                 w_load_init;
  logic                 w_init_adv;
  logic                 w_init_fin;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h30;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  assign w_init_done = r_init_done;
  assign w_init_sel  = w_init_adv ? (r_init_idx + 2'd1) : 2'd0;
`else
  assign w_init_done = 1'b1;
`endif

  // Clear (0x01) and home (0x02) commands need the long execution wait.
  assign w_gap_load = (!r_lcd_rs && (r_lcd_dat == 8'h01 || r_lcd_dat == 8'h02))
                    ? CNT_W'(CLEAR_GAP_CYC - 1) : CNT_W'(CMD_GAP_CYC - 1);

  // Round-robin arbiter: rotate valids so the pointer sits at bit 0, take the
  // lowest set bit, then rotate the offset back to a requester index.
  always_comb begin
    w_valid_dbl   = {req_valid, req_valid};
    w_valid_rot   = NUM_REQ'(w_valid_dbl >> r_ptr);
    w_grant_found = |w_valid_rot;
    w_off         = 0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (w_valid_rot[j]) w_off = j;
    end
    w_sum = int'(r_ptr) + w_off;
    if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
    w_nxt_sum = w_sum + 1;
    if (w_nxt_sum >= NUM_REQ) w_nxt_sum = 0;
    w_ptr_nxt  = PTR_W'(w_nxt_sum);
    w_grant_oh = '0;
    w_sel_rs   = 1'b0;
    w_sel_dat  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_sum == i) begin
        w_grant_oh[i] = 1'b1;
        w_sel_rs      = req_rs[i];
        w_sel_dat     = req_dat[8*i +: 8];
      end
    end
  end

  // Next-state logic; every state entry also reloads the timing counter.
  always_comb begin
    w_state_nxt = r_state;
    w_reload    = 1'b0;
    w_cnt_load  = '0;
    w_load_req  = 1'b0;
    w_ack_nxt   = '0;
`ifdef LCD_INIT_SEQ_EN
    w_load_init = 1'b0;
    w_init_adv  = 1'b0;
    w_init_fin  = 1'b0;
`endif
    case (r_state)
`ifdef LCD_INIT_SEQ_EN
      S_PWRUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_SETUP;
          w_reload    = 1'b1;
          w_cnt_load  = CNT_W'(SETUP_CYC - 1);
          w_load_init = 1'b1;
        end
      end
`endif
      S_IDLE: begin
        if (w_init_done && w_grant_found) begin
          w_state_nxt = S_SETUP;
          w_reload    = 1'b1;
          w_cnt_load  = CNT_W'(SETUP_CYC - 1);
          w_load_req  = 1'b1;
          w_ack_nxt   = w_grant_oh;
        end
      end
      S_SETUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_STROBE;
          w_reload    = 1'b1;
          w_cnt_load  = CNT_W'(EN_HIGH_CYC - 1);
        end
      end
      S_STROBE: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_HOLD;
          w_reload    = 1'b1;
          w_cnt_load  = CNT_W'(HOLD_CYC - 1);
        end
      end
      S_HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_GAP;
          w_reload    = 1'b1;
          w_cnt_load  = w_gap_load;
        end
      end
      S_GAP: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
`ifdef LCD_INIT_SEQ_EN
          // Init bytes run back to back; IDLE is only reached after the last.
          if (!r_init_done) begin
            if (r_init_idx == 2'd3) begin
              w_init_fin = 1'b1;
            end else begin
              w_state_nxt = S_SETUP;
              w_reload    = 1'b1;
              w_cnt_load  = CNT_W'(SETUP_CYC - 1);
              w_load_init = 1'b1;
              w_init_adv  = 1'b1;
            end
          end
`endif
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RESET;
    else     r_state <= w_state_nxt;
  end

  // Shared down-counter: reload on state entry, otherwise count to zero and stay.
  always_ff @(posedge clk) begin
    if (rst)                r_cnt <= CNT_W'(POWERUP_CYC - 1);
    else if (w_reload)      r_cnt <= w_cnt_load;
    else if (r_cnt != '0)   r_cnt <= r_cnt - CNT_W'(1);
  end

  // Bus registers, ack pulse and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lcd_rs  <= 1'b0;
      r_lcd_dat <= 8'h00;
      r_lcd_en  <= 1'b0;
      r_ack     <= '0;
      r_ptr     <= '0;
    end else begin
      r_lcd_en <= (w_state_nxt == S_STROBE);
      r_ack    <= w_ack_nxt;
      if (w_load_req) begin
        r_lcd_rs  <= w_sel_rs;
        r_lcd_dat <= w_sel_dat;
        r_ptr     <= w_ptr_nxt;
      end
`ifdef LCD_INIT_SEQ_EN
      else if (w_load_init) begin
        r_lcd_rs  <= 1'b0;
        r_lcd_dat <= init_byte(w_init_sel);
      end
`endif
    end
  end

`ifdef LCD_INIT_SEQ_EN
  // Init sequence progress; init_done is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_init_idx  <= 2'd0;
      r_init_done <= 1'b0;
    end else begin
      if (w_init_adv) r_init_idx  <= r_init_idx + 2'd1;
      if (w_init_fin) r_init_done <= 1'b1;
    end
  end
`endif

  assign req_ack   = r_ack;
  assign lcd_rs    = r_lcd_rs;
  assign lcd_rw    = 1'b0;
  assign lcd_en    = r_lcd_en;
  assign lcd_dat   = r_lcd_dat;
  assign init_done = w_init_done;
  assign busy      = (r_state != S_IDLE) || !w_init_done;

endmodule
